// File: rtl/gen_path_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_path_seq_pkg                                                     |
// | Shared FSM state type and default sizing for gen_path_seq.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gen_path_seq_pkg;

  localparam int c_def_num_w   = 5;
  localparam int c_def_max_grp = 3;
  localparam int c_def_dim_w   = $clog2(c_def_num_w);
  localparam int c_def_grp_w   = $clog2(c_def_max_grp + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIND = 2'd1,
    S_EMIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gen_path_seq_find_msb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | find_msb                                                             |
// | Index of the most significant set bit, plus a non-zero flag.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module find_msb
  import gen_path_seq_pkg::*;
#(
  parameter int NUM_W = c_def_num_w,
  parameter int DIM_W = $clog2(NUM_W)
) (
  input  logic [NUM_W-1:0] value,
  output logic [DIM_W-1:0] idx,
  output logic             nonzero
);

  // Ascending scan: the highest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_W; i++) begin
      if (value[i]) idx = DIM_W'(i);
    end
  end

  assign nonzero = |value;

endmodule
`default_nettype wire

// File: rtl/gen_path_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_path_seq                                                         |
// | Greedy power-of-two subcube decomposition, one beat per dimension.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gen_path_seq
  import gen_path_seq_pkg::*;
#(
  parameter  int NUM_W   = c_def_num_w,
  parameter  int MAX_GRP = c_def_max_grp,
  localparam int DIM_W   = $clog2(NUM_W),
  localparam int GRP_W   = $clog2(MAX_GRP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [GRP_W-1:0] out_grp,
  output logic [DIM_W-1:0] out_len,
  output logic [DIM_W-1:0] out_dim,
  output logic [NUM_W-1:0] out_base,
  output logic             out_last_dim,
  output logic             out_last,
  output logic             done,
  output logic [GRP_W-1:0] done_grp_cnt,
  output logic             done_ovf
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NUM_W-1:0] r_rem;
  logic [NUM_W-1:0] r_base;
  logic [GRP_W-1:0] r_grp;
  logic [DIM_W-1:0] r_len;
  logic [DIM_W-1:0] r_dim;

  logic [DIM_W-1:0] w_msb;
  logic             w_nonzero;
  logic [NUM_W-1:0] w_size;
  logic [NUM_W-1:0] w_rem_nxt;
  logic [DIM_W-1:0] w_len_m1;
  logic             w_last_dim;
  logic             w_more_grp;

  find_msb #(
    .NUM_W (NUM_W),
    .DIM_W (DIM_W)
  ) u_find_msb (
    .value   (r_rem),
    .idx     (w_msb),
    .nonzero (w_nonzero)
  );

  assign w_size     = NUM_W'(1) << r_len;
  assign w_rem_nxt  = r_rem - w_size;
  assign w_len_m1   = r_len - 1'b1;
  // A zero-dimension group still emits a single beat at dim 0.
  assign w_last_dim = (r_len == '0) || (r_dim == w_len_m1);
  assign w_more_grp = (int'(r_grp) + 1) < MAX_GRP;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_FIND;
      end
      S_FIND: w_state_nxt = w_nonzero ? S_EMIT : S_FIN;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && w_last_dim)
          w_state_nxt = ((w_rem_nxt != '0) && w_more_grp) ? S_FIND : S_FIN;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_base <= '0;
      r_grp  <= '0;
      r_len  <= '0;
      r_dim  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rem  <= in_num;
            r_base <= '0;
            r_grp  <= '0;
            r_len  <= '0;
            r_dim  <= '0;
          end
        end
        S_FIND: begin
          r_len <= w_msb;
          r_dim <= '0;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (w_last_dim) begin
              r_base <= r_base + w_size;
              r_rem  <= w_rem_nxt;
              r_grp  <= r_grp + 1'b1;
            end else begin
              r_dim  <= r_dim + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_grp      = r_grp;
  assign out_len      = r_len;
  assign out_dim      = r_dim;
  assign out_base     = r_base;
  assign out_last_dim = out_valid && w_last_dim;
  assign out_last     = out_valid && w_last_dim && ((w_rem_nxt == '0) || !w_more_grp);
  assign done_grp_cnt = done ? r_grp : '0;
  assign done_ovf     = done && (r_rem != '0);

endmodule
`default_nettype wire

// File: tb/tb_gen_path_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gen_path_seq                                                      |
// | Table, hand-written and random checks against a greedy-split model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gen_path_seq;

  localparam int NUM_W   = 5;
  localparam int MAX_GRP = 3;
  localparam int DIM_W   = 3;
  localparam int GRP_W   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NUM_W-1:0] in_num = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [GRP_W-1:0] out_grp;
  logic [DIM_W-1:0] out_len;
  logic [DIM_W-1:0] out_dim;
  logic [NUM_W-1:0] out_base;
  logic             out_last_dim;
  logic             out_last;
  logic             done;
  logic [GRP_W-1:0] done_grp_cnt;
  logic             done_ovf;

  gen_path_seq #(.NUM_W(NUM_W), .MAX_GRP(MAX_GRP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .out_valid(out_valid), .out_ready(out_ready), .out_grp(out_grp), .out_len(out_len),
    .out_dim(out_dim), .out_base(out_base), .out_last_dim(out_last_dim), .out_last(out_last),
    .done(done), .done_grp_cnt(done_grp_cnt), .done_ovf(done_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int grp; int len; int dim; int base; bit last_dim; bit last;
  } beat_t;

  typedef struct {
    int num; int cnt; int ovf; int beats;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  int    mdl_cnt;
  int    mdl_ovf;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Greedy split: largest power of two not above the remainder, up to MAX_GRP groups.
  task automatic build_model(input int num);
    int rem, base, g, n, span;
    beat_t b;
    exp_q.delete();
    rem = num; base = 0; g = 0;
    while (rem > 0 && g < MAX_GRP) begin
      n = 0;
      while ((2 << n) <= rem) n++;
      span = (n == 0) ? 1 : n;
      for (int d = 0; d < span; d++) begin
        b.grp = g; b.len = n; b.dim = d; b.base = base;
        b.last_dim = (d == span - 1); b.last = 1'b0;
        exp_q.push_back(b);
      end
      rem  -= (1 << n);
      base += (1 << n);
      g++;
    end
    if (exp_q.size() > 0) begin
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
    end
    mdl_cnt = g;
    mdl_ovf = (rem != 0) ? 1 : 0;
  endtask

  function automatic logic [31:0] pack_beat(int g, int l, int d, int b, bit ld, bit la);
    return (32'(g) << 20) | (32'(l) << 16) | (32'(d) << 12) | (32'(b) << 4) | (32'(ld) << 1) | 32'(la);
  endfunction

  // mode: 0 = always ready, 1 = ready toggles each cycle, 2 = random ready
  task automatic run_txn(input int num, input int mode, output int got_cnt, output int got_ovf,
                         output int got_beats, output int lat_valid, output int lat_done);
    int k; bit fin; bit stall; bit tog;
    int p_grp, p_len, p_dim, p_base;
    beat_t e;
    build_model(num);
    got_cnt = -1; got_ovf = -1; got_beats = 0; lat_valid = -1; lat_done = -1;
    fin = 1'b0; stall = 1'b0; tog = 1'b0;
    p_grp = 0; p_len = 0; p_dim = 0; p_base = 0;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin step(); k++; end
    check(in_ready === 1'b1, "ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_num   = NUM_W'(num);
    step();
    in_valid = 1'b0;
    k = 1;
    while (!fin && k < 200) begin
      check(in_ready === 1'b0, "busy_ready", 32'(in_ready), 32'd0);
      if (stall) begin
        check(out_valid === 1'b1 && int'(out_grp) == p_grp && int'(out_len) == p_len &&
              int'(out_dim) == p_dim && int'(out_base) == p_base, "stall_hold",
              pack_beat(int'(out_grp), int'(out_len), int'(out_dim), int'(out_base), 0, 0),
              pack_beat(p_grp, p_len, p_dim, p_base, 0, 0));
      end
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) begin out_ready = tog; tog = !tog; end
      else                out_ready = 1'($urandom_range(0, 1));
      if (out_valid === 1'b1) begin
        if (lat_valid < 0) lat_valid = k;
        if (out_ready) begin
          got_beats++;
          check(exp_q.size() != 0, "beat_expected", 32'(got_beats), 32'(mdl_cnt));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(int'(out_grp) == e.grp && int'(out_len) == e.len && int'(out_dim) == e.dim &&
                  int'(out_base) == e.base && out_last_dim == e.last_dim && out_last == e.last,
                  "beat",
                  pack_beat(int'(out_grp), int'(out_len), int'(out_dim), int'(out_base), out_last_dim, out_last),
                  pack_beat(e.grp, e.len, e.dim, e.base, e.last_dim, e.last));
          end
        end
        stall  = !out_ready;
        p_grp  = int'(out_grp); p_len = int'(out_len);
        p_dim  = int'(out_dim); p_base = int'(out_base);
      end else begin
        stall = 1'b0;
      end
      if (done === 1'b1) begin
        fin = 1'b1; lat_done = k;
        got_cnt = int'(done_grp_cnt); got_ovf = int'(done_ovf);
      end else begin
        step(); k++;
      end
    end
    check(fin, "done_seen", 32'(fin), 32'd1);
    check(got_cnt == mdl_cnt, "done_grp_cnt", 32'(got_cnt), 32'(mdl_cnt));
    check(got_ovf == mdl_ovf, "done_ovf", 32'(got_ovf), 32'(mdl_ovf));
    check(exp_q.size() == 0, "beats_left", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    step();
    check(in_ready === 1'b1 && done === 1'b0, "idle_after_done", {30'd0, in_ready, done}, 32'd2);
  endtask

  vec_t tbl[10];
  int   c, o, nb, lv, ld, k;
  bit   seen;

  initial begin
    tbl[0] = '{16, 1, 0, 4};
    tbl[1] = '{13, 3, 0, 6};
    tbl[2] = '{15, 3, 1, 6};
    tbl[3] = '{0,  0, 0, 0};
    tbl[4] = '{6,  2, 0, 3};
    tbl[5] = '{31, 3, 1, 9};
    tbl[6] = '{1,  1, 0, 1};
    tbl[7] = '{2,  1, 0, 1};
    tbl[8] = '{3,  2, 0, 2};
    tbl[9] = '{7,  3, 0, 4};

    rst = 1'b1;
    step(); step();
    check(in_ready === 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    check(out_valid === 1'b0 && done === 1'b0, "rst_valid_done", {30'd0, out_valid, done}, 32'd0);
    check(out_base === '0 && out_grp === '0 && out_last === 1'b0 && done_grp_cnt === '0 &&
          done_ovf === 1'b0, "rst_fields",
          pack_beat(int'(out_grp), 0, 0, int'(out_base), 0, out_last), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].num, (tbl[i].num == 6) ? 1 : 0, c, o, nb, lv, ld);
      check(c == tbl[i].cnt, "tbl_cnt", 32'(c), 32'(tbl[i].cnt));
      check(o == tbl[i].ovf, "tbl_ovf", 32'(o), 32'(tbl[i].ovf));
      check(nb == tbl[i].beats, "tbl_beats", 32'(nb), 32'(tbl[i].beats));
      if (tbl[i].num != 0) begin
        check(lv == 2, "first_valid_lat", 32'(lv), 32'd2);
      end else begin
        check(lv == -1, "zero_no_valid", 32'(lv), 32'hffffffff);
        check(ld == 2, "zero_done_lat", 32'(ld), 32'd2);
      end
    end

    // Abort in the middle of group 1 of a 31-node request.
    in_valid = 1'b1; in_num = NUM_W'(31);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (!(out_valid === 1'b1 && out_grp == 2'd1) && k < 50) begin step(); k++; end
    check(out_valid === 1'b1 && out_grp == 2'd1, "reach_grp1", 32'(out_grp), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check(out_valid === 1'b0 && done === 1'b0, "rst_abort", {30'd0, out_valid, done}, 32'd0);
    check(in_ready === 1'b1, "rst_abort_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1 || out_valid === 1'b1) seen = 1'b1;
    end
    check(!seen, "rst_no_activity", 32'(seen), 32'd0);
    out_ready = 1'b0;
    run_txn(2, 0, c, o, nb, lv, ld);
    check(c == 1 && o == 0 && nb == 1, "post_rst_txn", 32'(nb), 32'd1);

    for (int i = 0; i < 25; i++) begin
      run_txn(int'($urandom_range(0, 31)), 2, c, o, nb, lv, ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gen_path_seq.md
GEN_PATH_SEQ -- requirements
Module: gen_path_seq

Interface
REQ-001 Parameter NUM_W, default 5: width of the node-count request.
REQ-002 Parameter MAX_GRP, default 3: maximum number of subcube groups per request.
REQ-003 Derived constants: DIM_W = $clog2(NUM_W) (default 3); GRP_W = $clog2(MAX_GRP+1) (default 2).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 in_num  in  NUM_W  number of nodes to cover.
REQ-009 out_valid  out  1  path beat present.
REQ-010 out_ready  in  1  consumer accepts beat.
REQ-011 out_grp  out  GRP_W  group index of the beat, 0-based.
REQ-012 out_len  out  DIM_W  group dimension n (group size 2^n).
REQ-013 out_dim  out  DIM_W  dimension index of the beat, 0..n-1 (0 when n=0).
REQ-014 out_base  out  NUM_W  first node index of the group (sum of earlier group sizes).
REQ-015 out_last_dim  out  1  last beat of the current group.
REQ-016 out_last  out  1  last beat of the request.
REQ-017 done  out  1  one-cycle pulse when a request completes.
REQ-018 done_grp_cnt  out  GRP_W  number of groups emitted; valid with done.
REQ-019 done_ovf  out  1  remainder non-zero after MAX_GRP groups; valid with done.

Function
REQ-020 The block SHALL decompose in_num greedily: rem=in_num; per group, n = index of the most significant set bit of rem, size = 2^n, rem = rem - size.
REQ-021 The FSM SHALL have states IDLE, FIND, EMIT, FIN; in_ready = 1 only in IDLE.
REQ-022 IDLE->FIND on in_valid&&in_ready; in_num SHALL be registered into rem; base and grp SHALL be cleared.
REQ-023 FIND SHALL take exactly one cycle: latch n = msb(rem), dim=0, then ->EMIT; if rem==0, ->FIN with no beat emitted.
REQ-024 Latency SHALL be: request accepted at cycle T, first out_valid at T+2.
REQ-025 EMIT SHALL present one beat per dimension 0..n-1 (one beat with out_dim=0 if n=0); dim advances only on out_valid&&out_ready.
REQ-026 All out_* fields SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 On acceptance of the last_dim beat: base += 2^n, rem -= 2^n, grp += 1; then ->FIND if rem!=0 and grp+1<MAX_GRP, otherwise ->FIN.
REQ-028 out_last SHALL be 1 on the last_dim beat when rem-2^n==0 or grp==MAX_GRP-1.
REQ-029 FIN SHALL pulse done for one cycle with done_grp_cnt = groups emitted, done_ovf = (remaining rem!=0), then ->IDLE.
REQ-030 in_num==0 SHALL produce no beats and done with grp_cnt=0, ovf=0, at T+2.
REQ-031 Arithmetic SHALL be unsigned, NUM_W bits; base never exceeds in_num, so no wrap occurs.
REQ-032 in_valid while busy SHALL be ignored (in_ready=0); the request stays pending upstream.

Reset
REQ-033 rst SHALL force IDLE, in_ready=1, out_valid=0, done=0, and zero all out_*, done_* and internal registers on the next clock edge.
REQ-034 rst mid-request SHALL abort it: no further beats and no done pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the NUM_W/MAX_GRP defaults and the derived DIM_W/GRP_W constants.
REQ-036 The msb search SHALL be one combinational sub-module find_msb (parametrised NUM_W, outputs DIM_W index and a nonzero flag).

Verification
REQ-037 in_num=16, out_ready=1 -> 4 beats grp0 len4 dims0..3 base0, out_last on dim3; done grp_cnt=1 ovf=0.
REQ-038 in_num=13 -> grp0 len3 base0 dims0..2; grp1 len2 base8 dims0,1; grp2 len0 base12 one beat with out_last; done grp_cnt=3 ovf=0.
REQ-039 in_num=15, MAX_GRP=3 -> groups len3/2/1 at bases 0/8/12, out_last on grp2 dim0; done grp_cnt=3 ovf=1.
REQ-040 in_num=0 -> no out_valid; done at T+2 with grp_cnt=0 ovf=0; in_ready returns to 1 at T+3.
REQ-041 in_num=6 with out_ready toggling 0/1 every cycle -> beat fields stable while stalled; sequence grp0 len2 dims0,1 base0 then grp1 len1 dim0 base4.
REQ-042 in_num=31, rst asserted during grp1 -> out_valid=0 the next cycle, no done pulse; a following in_num=2 completes normally.
